// File: rtl/conv55_pkg.sv
// Shared constants and tap-packing helper for the 5x5 window front end and conv engine.
package conv55_pkg;

  localparam int DATA_W = 6;
  localparam int K      = 5;
  localparam int NTAPS  = K * K;
  localparam int NLB    = K - 1;

  // One input beat as seen by the window generator
  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } pix_t;

  // Bit offset of tap (r,c) in the flat window bus; r=0 oldest row, c=0 oldest column
  function automatic int tap_lsb(input int r, input int c);
    return (r * K + c) * DATA_W;
  endfunction

endpackage

// File: rtl/conv55_line_buffer.sv
// Single-line delay: reads the pixel stored one line ago at addr, then overwrites it.
module conv55_line_buffer
  import conv55_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [IMG_W];

  // Read-before-write: dout is the previous line's pixel at this column
  assign dout = mem[addr];

  // Contents need no reset; rows < 4 are never emitted so stale data is harmless
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/conv55_window_gen.sv
// Raster-scan to 5x5 sliding window generator with single-register output handshake.
module conv55_window_gen
  import conv55_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_sof,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NTAPS*DATA_W-1:0] out_window,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  pix_t                               in_pix;
  logic                               accept;
  logic [CW-1:0]                      col, eff_col, nxt_col;
  logic [RW-1:0]                      row, eff_row, nxt_row;
  logic                               col_wrap, emit, last_pos;
  logic [NLB-1:0][DATA_W-1:0]         lb_in, lb_out;
  logic [K-1:0][DATA_W-1:0]           col_new;
  logic [K-1:0][K-1:0][DATA_W-1:0]    win;

  assign in_pix   = '{sof: in_sof, data: in_data};
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Position of the current beat (sof forces 0,0) and the position after it
  always_comb begin
    eff_col  = in_pix.sof ? '0 : col;
    eff_row  = in_pix.sof ? '0 : row;
    col_wrap = (eff_col == CW'(IMG_W - 1));
    nxt_col  = col_wrap ? '0 : eff_col + 1'b1;
    nxt_row  = eff_row;
    if (col_wrap) nxt_row = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
    emit     = (eff_row >= RW'(K - 1)) && (eff_col >= CW'(K - 1));
    last_pos = (eff_row == RW'(IMG_H - 1)) && col_wrap;
  end

  // Raster counters advance once per accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

  // Line-buffer chain: stage i outputs the pixel from i+1 lines ago
  always_comb begin
    lb_in[0] = in_pix.data;
    for (int i = 1; i < NLB; i++) lb_in[i] = lb_out[i-1];
  end

  for (genvar i = 0; i < NLB; i++) begin : g_lb
    conv55_line_buffer #(.IMG_W(IMG_W), .AW(CW)) u_lb (
      .clk  (clk),
      .we   (accept),
      .addr (eff_col),
      .din  (lb_in[i]),
      .dout (lb_out[i])
    );
  end

  // New right column: row 4 is the live pixel, row 0 the oldest line
  always_comb begin
    col_new[K-1] = in_pix.data;
    for (int r = 0; r < K - 1; r++) col_new[r] = lb_out[K-2-r];
  end

  // Window shifts left one column per accepted pixel; frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= col_new[r];
      end
    end
  end

  // Flatten taps onto the conv engine input bus
  always_comb begin
    out_window = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        out_window[tap_lsb(r, c) +: DATA_W] = win[r][c];
  end

  // Output handshake: load on completing pixel, clear on drain without refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= emit;
      out_last  <= emit && last_pos;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv55_window_gen.sv
// Self-checking bench for conv55_window_gen with a frame-array reference model.
module tb_conv55_window_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WB = 150;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    in_data;
  logic          in_sof;
  logic          in_valid;
  logic          in_ready;
  logic [WB-1:0] out_window;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  conv55_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_window (out_window),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [WB-1:0] win;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [WB-1:0] rx_q[$];
  logic [5:0]    img [H][W];
  int            mr = 0, mc = 0;
  bit            pend_emit = 0;
  bit            stalled_prev = 0;
  logic [WB-1:0] held_win;
  logic          held_last;
  int            lasts = 0;
  int            stall_cnt = 0;
  int            rdy_mode = 0;
  int            stall_left = 0;

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int tap(input logic [WB-1:0] w, input int k);
    return int'(w[k*6 +: 6]);
  endfunction

  // Reference model and monitor: observe handshakes half a cycle before the edge that takes them
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend_emit) chk("latency_valid", out_valid, 1);
      pend_emit = 0;
      if (stalled_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_window", out_window, held_win);
        chk("hold_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_window", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("window_taps", out_window, e.win);
          chk("window_last", out_last, e.last);
        end
        rx_q.push_back(out_window);
        if (out_last) lasts++;
      end
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", in_ready, 0);
        stall_cnt++;
      end
      stalled_prev = out_valid && !out_ready;
      held_win     = out_window;
      held_last    = out_last;
      if (in_valid && in_ready) begin
        if (in_sof) begin mr = 0; mc = 0; end
        img[mr][mc] = in_data;
        if (mr >= 4 && mc >= 4) begin
          exp_t e;
          e.win = '0;
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              e.win[(r*5+c)*6 +: 6] = img[mr-4+r][mc-4+c];
          e.last = (mr == H-1) && (mc == W-1);
          exp_q.push_back(e);
          pend_emit = 1;
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr == H-1) ? 0 : mr + 1;
        end
      end
    end
  end

  // Consumer: always ready, random, one 3-cycle stall on the 2nd window, or never ready
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 1) == 1);
      2: if (out_valid && rx_q.size() == 1 && stall_left > 0) begin
           out_ready = 1'b0;
           stall_left--;
         end else out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send_pix(input logic [5:0] d, input logic sof, input bit rnd);
    int guard = 0;
    forever begin
      @(posedge clk); #1;
      in_data  = d;
      in_sof   = sof;
      in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) break;
      guard++;
      if (guard > 1000) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_frame(input int off, input bit rnd_data, input bit rnd_valid, input bit sof0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(rnd_data ? 6'($urandom) : 6'((r*W + c + off) % 64),
                 sof0 && r == 0 && c == 0, rnd_valid);
  endtask

  task automatic wait_drain();
    int n = 0;
    idle(1);
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", (n < 1000), 1);
  endtask

  typedef struct {
    string nm;
    int    nfr;
    bit    rnd;
    int    rdy;
    int    exp_win;
    int    exp_last;
    int    f0, f12, f24;
    int    l0, l24;
    int    s0, s24;
  } scen_t;

  scen_t tbl[3];

  initial begin
    tbl[0] = '{"single",  1, 1'b0, 0,  8, 1,  0, 18, 36, 11, 47, -1, -1};
    tbl[1] = '{"b2b",     2, 1'b0, 0, 16, 2,  0, 18, 36, 12, 48,  1, 37};
    tbl[2] = '{"random",  3, 1'b1, 1, 24, 3, -1, -1, -1, -1, -1, -1, -1};

    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_window", out_window, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int s = 0; s < 3; s++) begin
      rdy_mode = tbl[s].rdy;
      rx_q.delete(); lasts = 0;
      for (int f = 0; f < tbl[s].nfr; f++) send_frame(f, tbl[s].rnd, tbl[s].rnd, 1'b1);
      wait_drain();
      chk({tbl[s].nm, "_count"}, rx_q.size(), tbl[s].exp_win);
      chk({tbl[s].nm, "_lasts"}, lasts, tbl[s].exp_last);
      if (tbl[s].f0 >= 0 && rx_q.size() > 0) begin
        chk({tbl[s].nm, "_first_t0"},  tap(rx_q[0], 0),  tbl[s].f0);
        chk({tbl[s].nm, "_first_t12"}, tap(rx_q[0], 12), tbl[s].f12);
        chk({tbl[s].nm, "_first_t24"}, tap(rx_q[0], 24), tbl[s].f24);
        chk({tbl[s].nm, "_last_t0"},   tap(rx_q[rx_q.size()-1], 0),  tbl[s].l0);
        chk({tbl[s].nm, "_last_t24"},  tap(rx_q[rx_q.size()-1], 24), tbl[s].l24);
      end
      if (tbl[s].s0 >= 0 && rx_q.size() > 8) begin
        chk({tbl[s].nm, "_f2_t0"},  tap(rx_q[8], 0),  tbl[s].s0);
        chk({tbl[s].nm, "_f2_t24"}, tap(rx_q[8], 24), tbl[s].s24);
      end
    end

    // Backpressure: 3-cycle stall on the second window
    rdy_mode = 2; stall_left = 3; stall_cnt = 0; rx_q.delete();
    send_frame(0, 1'b0, 1'b0, 1'b1);
    wait_drain();
    chk("bp_stall_cycles", stall_cnt, 3);
    chk("bp_count", rx_q.size(), 8);

    // Resync: sof on the 20th pixel restarts the raster there
    rdy_mode = 0; rx_q.delete();
    for (int i = 0; i < 19; i++) send_pix(6'(i), 1'b0, 1'b0);
    send_pix(6'd0, 1'b1, 1'b0);
    for (int i = 1; i < 36; i++) send_pix(6'(i), 1'b0, 1'b0);
    idle(3);
    chk("resync_early_count", rx_q.size(), 0);
    chk("resync_early_valid", out_valid, 0);
    send_pix(6'd36, 1'b0, 1'b0);
    idle(2);
    chk("resync_first_count", rx_q.size(), 1);
    for (int i = 37; i < 48; i++) send_pix(6'(i), 1'b0, 1'b0);
    wait_drain();
    chk("resync_count", rx_q.size(), 8);
    if (rx_q.size() > 0) chk("resync_first_t24", tap(rx_q[0], 24), 36);

    // Reset mid-frame with a window pending
    rdy_mode = 3; rx_q.delete();
    for (int i = 0; i < 37; i++) send_pix(6'(i), i == 0, 1'b0);
    idle(2);
    chk("pre_rst_valid", out_valid, 1);
    #3 rst_n = 1'b0;
    exp_q.delete(); mr = 0; mc = 0; pend_emit = 0; stalled_prev = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_last", out_last, 0);
    chk("midrst_window", out_window, 0);
    rdy_mode = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    rx_q.delete(); lasts = 0;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    chk("postrst_count", rx_q.size(), 8);
    chk("postrst_lasts", lasts, 1);
    if (rx_q.size() > 0) begin
      chk("postrst_t0",  tap(rx_q[0], 0),  0);
      chk("postrst_t12", tap(rx_q[0], 12), 18);
      chk("postrst_t24", tap(rx_q[0], 24), 36);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv55_window_gen.md
Name: conv55_window_gen

Overview:
- Streaming front end for the 5x5, 6-bit convolution datapath.
- Accepts a raster-scan pixel stream, one pixel per handshake.
- Keeps 4 line buffers plus a 5x5 window register, and emits one full 25-tap window per valid output position ("valid" convolution, no padding).
- Its output bus maps one-to-one onto the conv engine's 25 in_data inputs.

Parameters:
- DATA_W, 6: pixel width in bits.
- IMG_W, 32: pixels per line; must be ≥ 5.
- IMG_H, 32: lines per frame; must be ≥ 5.
- K, 5: window edge. Fixed at 5; only the value 5 is supported.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  pixel.
- in_sof  in  1  marks the first pixel of a frame; sampled only on an accepted beat.
- in_valid  in  1  pixel present.
- in_ready  out  1  block can accept a pixel.
- out_window  out  K*K*DATA_W (150)  flat 25-tap window.
- out_valid  out  1  window present.
- out_ready  in  1  consumer accepts the window.
- out_last  out  1  final window of the frame; qualified by out_valid.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_last=0, out_window=0.
  - Column/row counters = 0; window register = 0.
  - in_ready=1 after release.
  - Line buffer contents are don't-care.
- Accept rules:
  - A pixel is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, so the single output register can be refilled in the same cycle it drains.
- Per accepted pixel:
  - Write it into the line-buffer chain at the current column.
  - Shift the window register one column left.
  - Load the new right column from the 4 line-buffer outputs plus the incoming pixel.
- Counters:
  - col increments per accepted pixel and wraps IMG_W-1 → 0.
  - On the wrap, row increments; row wraps IMG_H-1 → 0, so back-to-back frames need no gap.
- Frame resync:
  - An accepted beat with in_sof=1 forces that pixel to (row 0, col 0) regardless of counter state.
  - No window is emitted for the discarded partial frame beyond those already produced.
  - in_sof on the natural (0,0) position is a no-op.
- Window emission:
  - An accepted pixel at (row, col) with row ≥ 4 and col ≥ 4 completes a window.
  - out_valid rises the next cycle (latency 1 from acceptance).
  - Windows per frame = (IMG_H-4)*(IMG_W-4).
  - Positions with col < 4 (window spans the line wrap) and rows < 4 are never emitted.
- Tap packing:
  - Tap k = r*5+c occupies out_window[k*DATA_W +: DATA_W].
  - r=0 is the oldest row (row-4); c=0 is the oldest column (col-4).
  - Tap 24 is the just-accepted pixel.
- out_last=1 with the window completed at (IMG_H-1, IMG_W-1).
- Hold rule: while out_valid && !out_ready, out_window and out_last hold stable and no pixel is accepted.
- out_valid falls after out_ready unless a new window is produced the same cycle.
- Simultaneous event: accept and output drain in the same cycle is legal and lossless.
- Reset mid-frame: the pending window is dropped, counters clear, and the next accepted pixel is (0,0) whether or not in_sof is set.
- Status states, encoded by counters only: FILL (row < 4), RUN (row ≥ 4).

Decomposition:
- Package conv55_pkg holds:
  - DATA_W and K constants.
  - NTAPS = K*K.
  - Function tap_lsb(r,c) = (r*K+c)*DATA_W, shared with the conv engine wrapper.
- One sub-module, conv55_line_buffer:
  - IMG_W-deep, DATA_W-wide single-line delay, built on a circular write/read pointer driven by the shared col counter.
  - Instantiated 4 times in a chain.

Test Plan:
All scenarios use IMG_W=8, IMG_H=6, pixel = (row*8+col) mod 64 unless stated.
- Single frame, out_ready=1, in_valid always high:
  - Expect exactly 8 windows.
  - First window: tap0=0, tap12=18, tap24=36, out_valid 1 cycle after pixel 36 is accepted.
  - Last window: tap0=11, tap24=47, out_last=1.
- Backpressure:
  - out_ready=0 for 3 cycles on the 2nd window → in_ready=0 and out_window stable for those 3 cycles.
  - Afterwards, 8 windows total are received with no loss or duplication.
- Two back-to-back frames, second frame offset by +1 mod 64:
  - Expect 16 windows; frame-2 first window tap0=1, tap24=37.
  - Exactly 2 out_last pulses.
- Resync: in_sof asserted on the 20th pixel of a frame → counting restarts there; the next window appears only after 36 further accepted pixels.
- Random in_valid/out_ready at 50% each for 3 frames → windows match the reference model tap-for-tap, count 24.
- Reset mid-frame: rst_n pulsed low while out_valid=1 → out_valid=0 immediately; the following clean frame yields 8 correct windows.
